fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the IF stage against a variable-latency instruction memory (req/ack).
//  Owns the fetch PC and issues one request at a time. Delivers {instr, pc, pc+4} to the IF/ID register with load/bubble controls.
//  Applies stall (StallF) and redirect (PCSrcE/PCTargetE) from EX/hazard logic, and drops stale responses after a redirect.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset
//  MAX_WAIT  16             consecutive no-ack cycles before entering ERR (>=1)
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst            in   1   reset, synchronous, active-high
//  stall_i        in   1   IF/ID must hold its contents this cycle
//  redirect_i     in   1   taken branch/jump resolved in EX
//  redirect_pc_i  in   32  redirect target
//  imem_req_o     out  1   fetch request valid
//  imem_addr_o    out  32  fetch address; stable while imem_req_o=1 and no ack
//  imem_ack_i     in   1   response valid for the outstanding request
//  imem_rdata_i   in   32  instruction word, valid with imem_ack_i
//  instr_o        out  32  instruction presented to IF/ID
//  pc_o           out  32  PC of instr_o
//  pcplus4_o      out  32  pc_o + 4, mod 2^32
//  ifid_load_o    out  1   IF/ID captures this cycle
//  ifid_bubble_o  out  1   IF/ID captures NOP/zero instead of instr_o
//  fetch_err_o    out  1   sticky memory timeout flag
// BEHAVIOUR
//  State: st{FETCH,DROP,HOLD,ERR}, pc_q, tgt_q, buf_instr, buf_pc, wait_cnt[$clog2(MAX_WAIT+1)-1:0].
//  Reset (rst=1 at posedge):
//   - st=FETCH, pc_q=RESET_PC, buffers=0, wait_cnt=0, err=0.
//   - While rst=1, outputs are forced: req=0, load=1, bubble=1, instr/pc=0.
//   - rst mid-request abandons it; the memory must drop it on rst.
//  Redirect targets: bits[1:0] forced to 0. PC increment is +4 and wraps 32'hFFFF_FFFC -> 0.
//  Global output rules: ifid_load_o = ~stall_i | redirect_i; ifid_bubble_o=1 unless a valid word is delivered.
//  FETCH (req=1, addr=pc_q):
//   - redirect_i:
//     * ack this cycle -> drop data, pc_q<=tgt, stay FETCH.
//     * no ack -> tgt_q<=tgt, go DROP.
//     * bubble in both cases.
//   - ack & ~stall_i -> deliver combinationally (instr_o=rdata, pc_o=pc_q, bubble=0); pc_q+=4; stay FETCH. Zero-cycle ack->load latency.
//   - ack & stall_i -> buf<=rdata,pc_q; pc_q+=4; go HOLD.
//   - no ack -> bubble, wait_cnt++.
//  DROP (req=1, addr=pc_q; old address held):
//   - Bubble.
//   - Further redirect: tgt_q<=new target (latest wins).
//   - On ack (same-cycle redirect target wins over tgt_q) -> pc_q<=tgt_q, go FETCH; data discarded.
//  HOLD (req=0):
//   - instr_o/pc_o = buffer.
//   - redirect_i -> discard buffer, pc_q<=tgt, go FETCH, bubble. Redirect beats stall.
//   - else ~stall_i -> deliver buffer (bubble=0), go FETCH.
//  ERR (req=0):
//   - fetch_err_o=1, bubble=1; exit only by rst.
//   - redirect_i ignored.
//  wait_cnt:
//   - Cleared on any ack or state change; counts cycles in FETCH/DROP without ack.
//   - Reaching MAX_WAIT -> ERR next cycle; ack in that same cycle wins.
//  pcplus4_o = pc_o+4 in all states. instr_o/pc_o are don't-care when bubble=1, but driven to 0.
// TESTING
//  1. Reset, ack every cycle, no stall:
//     -> addrs 0,4,8,C; each load=1, bubble=0, pc_o matches, pcplus4_o=pc_o+4.
//  2. Ack latency 3 cycles:
//     -> req/addr held 3 cycles; load=1, bubble=1 on waits; word delivered on ack cycle.
//  3. Stall for 2 cycles on ack @0x8:
//     -> HOLD, req=0, instr held; released cycle delivers 0x8; next req addr 0xC.
//  4. Redirect to 0x103 while req@0x10 pending, ack 2 cycles later:
//     -> ack data not delivered (bubble); next req addr 0x100.
//  5. Redirect and ack same cycle, and redirect during HOLD+stall:
//     -> data dropped, next addr = target, load=1, bubble=1.
//  6. MAX_WAIT=4, no ack:
//     -> fetch_err_o=1 after 4 wait cycles, req=0; rst clears it, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the IF stage.
// Issues one request at a time to a variable-latency instruction memory
// (req/ack) and owns the fetch PC. It presents {instr, pc, pc+4} to IF/ID
// along with the load and bubble controls. Stall and redirect come from
// EX/hazard logic. A response that arrives after a redirect is discarded.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_FETCH | request outstanding at r_pc; an ack may be delivered directly
// ST_DROP  | redirected while a request was in flight; waiting to discard it
// ST_HOLD  | word captured while stalled; waiting to hand it to IF/ID
// ST_ERR   | memory timed out; only reset leaves this state
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pcplus4_o,
    output logic        ifid_load_o,
    output logic        ifid_bubble_o,
    output logic        fetch_err_o
);

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DROP  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    state_t           r_st;
    logic [31:0]      r_pc;
    logic [31:0]      r_tgt;
    logic [31:0]      r_buf_instr;
    logic [31:0]      r_buf_pc;
    logic [WCW-1:0]   r_wait_cnt;
    logic             r_err;

    state_t           w_st_nxt;
    logic [31:0]      w_pc_nxt;
    logic [31:0]      w_tgt_nxt;
    logic [31:0]      w_buf_instr_nxt;
    logic [31:0]      w_buf_pc_nxt;
    logic [WCW-1:0]   w_wait_nxt;
    logic             w_err_nxt;

    logic             w_req;
    logic [31:0]      w_instr;
    logic [31:0]      w_pc_out;
    logic             w_bubble;

    logic [31:0]      w_redirect_tgt;
    logic [31:0]      w_pc_inc;
    logic             w_timeout;

    assign w_redirect_tgt = {redirect_pc_i[31:2], 2'b00};
    assign w_pc_inc       = r_pc + 32'd4;
    // This cycle is the MAX_WAIT-th consecutive one without an ack.
    assign w_timeout      = (r_wait_cnt == WAIT_LAST);

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_st        <= ST_FETCH;
            r_pc        <= RESET_PC;
            r_tgt       <= '0;
            r_buf_instr <= '0;
            r_buf_pc    <= '0;
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_st        <= w_st_nxt;
            r_pc        <= w_pc_nxt;
            r_tgt       <= w_tgt_nxt;
            r_buf_instr <= w_buf_instr_nxt;
            r_buf_pc    <= w_buf_pc_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_err       <= w_err_nxt;
        end
    end

    // Next-state, register updates and IF/ID presentation.
    always_comb begin
        w_st_nxt        = r_st;
        w_pc_nxt        = r_pc;
        w_tgt_nxt       = r_tgt;
        w_buf_instr_nxt = r_buf_instr;
        w_buf_pc_nxt    = r_buf_pc;
        w_wait_nxt      = '0;
        w_err_nxt       = r_err;
        w_req           = 1'b0;
        w_instr         = '0;
        w_pc_out        = '0;
        w_bubble        = 1'b1;

        case (r_st)
            ST_FETCH: begin
                w_req = 1'b1;
                if (imem_ack_i) begin
                    if (redirect_i) begin
                        w_pc_nxt = w_redirect_tgt;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                        if (stall_i) begin
                            w_buf_instr_nxt = imem_rdata_i;
                            w_buf_pc_nxt    = r_pc;
                            w_st_nxt        = ST_HOLD;
                        end else begin
                            w_instr  = imem_rdata_i;
                            w_pc_out = r_pc;
                            w_bubble = 1'b0;
                        end
                    end
                end else if (w_timeout) begin
                    // A dead memory outranks a redirect: nothing can be fetched anyway.
                    w_st_nxt  = ST_ERR;
                    w_err_nxt = 1'b1;
                end else if (redirect_i) begin
                    w_tgt_nxt = w_redirect_tgt;
                    w_st_nxt  = ST_DROP;
                end else begin
                    w_wait_nxt = r_wait_cnt + WCW'(1);
                end
            end
            ST_DROP: begin
                w_req = 1'b1;
                if (imem_ack_i) begin
                    w_pc_nxt = redirect_i ? w_redirect_tgt : r_tgt;
                    w_st_nxt = ST_FETCH;
                end else if (w_timeout) begin
                    w_st_nxt  = ST_ERR;
                    w_err_nxt = 1'b1;
                end else begin
                    if (redirect_i) begin
                        w_tgt_nxt = w_redirect_tgt;
                    end
                    w_wait_nxt = r_wait_cnt + WCW'(1);
                end
            end
            ST_HOLD: begin
                w_instr  = r_buf_instr;
                w_pc_out = r_buf_pc;
                if (redirect_i) begin
                    w_pc_nxt = w_redirect_tgt;
                    w_st_nxt = ST_FETCH;
                end else if (!stall_i) begin
                    w_bubble = 1'b0;
                    w_st_nxt = ST_FETCH;
                end
            end
            ST_ERR: begin
                w_err_nxt = 1'b1;
            end
            default: begin
                w_st_nxt = ST_FETCH;
            end
        endcase
    end

    // While reset is held, IF/ID is kept loading bubbles and nothing is requested.
    assign imem_req_o    = w_req & ~rst;
    assign imem_addr_o   = r_pc;
    assign instr_o       = rst ? 32'h0 : w_instr;
    assign pc_o          = rst ? 32'h0 : w_pc_out;
    assign pcplus4_o     = pc_o + 32'd4;
    assign ifid_load_o   = rst | ~stall_i | redirect_i;
    assign ifid_bubble_o = rst | w_bubble;
    assign fetch_err_o   = r_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios plus a randomized run
// checked against a request/stale/held reference model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pcplus4_o;
    logic        ifid_load_o;
    logic        ifid_bubble_o;
    logic        fetch_err_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i), .instr_o(instr_o),
        .pc_o(pc_o), .pcplus4_o(pcplus4_o), .ifid_load_o(ifid_load_o),
        .ifid_bubble_o(ifid_bubble_o), .fetch_err_o(fetch_err_o)
    );

    // Instruction memory contents as a function of address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Advance one cycle, release reset, and apply this cycle's inputs.
    task automatic drive(input logic st, input logic rd, input logic [31:0] tgt, input logic ak);
        @(posedge clk); #1;
        rst = 1'b0;
        stall_i = st; redirect_i = rd; redirect_pc_i = tgt; imem_ack_i = ak;
        imem_rdata_i = ak ? memf(imem_addr_o) : 32'hDEAD_BEEF;
        #1;
    endtask

    // Raise reset for the next edge; the following drive() releases it.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; imem_ack_i = 1'b0; redirect_pc_i = '0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; stall_i = 1'b1; imem_ack_i = 1'b1; redirect_i = 1'b0;
        #1;
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req_o); end
        checks++; if (ifid_load_o !== 1'b1) begin errors++; $display("FAIL rst_load got=%b exp=1", ifid_load_o); end
        checks++; if (ifid_bubble_o !== 1'b1) begin errors++; $display("FAIL rst_bubble got=%b exp=1", ifid_bubble_o); end
        checks++; if (instr_o !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=0", instr_o); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=0", pc_o); end
        @(posedge clk); #1;
        checks++; if (fetch_err_o !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", fetch_err_o); end
        drive(0, 0, 0, 0);
        checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL rst_first_req got=%b exp=1", imem_req_o); end
        checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_first_addr got=%h exp=0", imem_addr_o); end
    endtask

    task automatic test_stream();
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a = 32'(i) * 32'd4;
            drive(0, 0, 0, 1);
            checks++; if (imem_addr_o !== a) begin errors++; $display("FAIL stream_addr got=%h exp=%h", imem_addr_o, a); end
            checks++; if (ifid_load_o !== 1'b1) begin errors++; $display("FAIL stream_load got=%b exp=1", ifid_load_o); end
            checks++; if (ifid_bubble_o !== 1'b0) begin errors++; $display("FAIL stream_bubble got=%b exp=0", ifid_bubble_o); end
            checks++; if (pc_o !== a) begin errors++; $display("FAIL stream_pc got=%h exp=%h", pc_o, a); end
            checks++; if (instr_o !== memf(a)) begin errors++; $display("FAIL stream_instr got=%h exp=%h", instr_o, memf(a)); end
            checks++; if (pcplus4_o !== a + 32'd4) begin errors++; $display("FAIL stream_pc4 got=%h exp=%h", pcplus4_o, a + 32'd4); end
        end
    endtask

    task automatic test_latency();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0);
            checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin errors++; $display("FAIL lat_req got=%b/%h exp=1/00000010", imem_req_o, imem_addr_o); end
            checks++; if (ifid_load_o !== 1'b1 || ifid_bubble_o !== 1'b1) begin errors++; $display("FAIL lat_wait got=%b%b exp=11", ifid_load_o, ifid_bubble_o); end
        end
        drive(0, 0, 0, 1);
        checks++; if (ifid_bubble_o !== 1'b0 || pc_o !== 32'h10) begin errors++; $display("FAIL lat_deliver got=%b/%h exp=0/00000010", ifid_bubble_o, pc_o); end
        checks++; if (instr_o !== memf(32'h10)) begin errors++; $display("FAIL lat_instr got=%h exp=%h", instr_o, memf(32'h10)); end
    endtask

    task automatic test_stall_hold();
        do_reset();
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 1);
        checks++; if (imem_addr_o !== 32'h8 || ifid_load_o !== 1'b0) begin errors++; $display("FAIL hold_capture got=%h/%b exp=00000008/0", imem_addr_o, ifid_load_o); end
        drive(1, 0, 0, 0);
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL hold_req got=%b exp=0", imem_req_o); end
        checks++; if (instr_o !== memf(32'h8) || pc_o !== 32'h8) begin errors++; $display("FAIL hold_instr got=%h/%h exp=%h/00000008", instr_o, pc_o, memf(32'h8)); end
        checks++; if (ifid_load_o !== 1'b0) begin errors++; $display("FAIL hold_load got=%b exp=0", ifid_load_o); end
        drive(0, 0, 0, 0);
        checks++; if (ifid_load_o !== 1'b1 || ifid_bubble_o !== 1'b0) begin errors++; $display("FAIL hold_release got=%b%b exp=10", ifid_load_o, ifid_bubble_o); end
        checks++; if (pc_o !== 32'h8 || instr_o !== memf(32'h8) || pcplus4_o !== 32'hC) begin errors++; $display("FAIL hold_release_data got=%h/%h/%h", pc_o, instr_o, pcplus4_o); end
        drive(0, 0, 0, 1);
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hC) begin errors++; $display("FAIL hold_next got=%b/%h exp=1/0000000c", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_redirect_pending();
        do_reset();
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
        drive(0, 1, 32'h103, 0);
        checks++; if (imem_addr_o !== 32'h10 || ifid_bubble_o !== 1'b1 || ifid_load_o !== 1'b1) begin errors++; $display("FAIL rdp_issue got=%h/%b%b", imem_addr_o, ifid_bubble_o, ifid_load_o); end
        drive(0, 0, 0, 0);
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin errors++; $display("FAIL rdp_hold_addr got=%b/%h exp=1/00000010", imem_req_o, imem_addr_o); end
        drive(0, 0, 0, 1);
        checks++; if (ifid_bubble_o !== 1'b1) begin errors++; $display("FAIL rdp_drop got=%b exp=1", ifid_bubble_o); end
        drive(0, 0, 0, 1);
        checks++; if (imem_addr_o !== 32'h100) begin errors++; $display("FAIL rdp_target got=%h exp=00000100", imem_addr_o); end
        checks++; if (ifid_bubble_o !== 1'b0 || pc_o !== 32'h100) begin errors++; $display("FAIL rdp_deliver got=%b/%h", ifid_bubble_o, pc_o); end
    endtask

    task automatic test_redirect_same_cycle();
        drive(0, 1, 32'h200, 1);
        checks++; if (ifid_bubble_o !== 1'b1 || ifid_load_o !== 1'b1) begin errors++; $display("FAIL rds_same got=%b%b exp=11", ifid_bubble_o, ifid_load_o); end
        drive(1, 0, 0, 1);
        checks++; if (imem_addr_o !== 32'h200) begin errors++; $display("FAIL rds_target got=%h exp=00000200", imem_addr_o); end
        drive(1, 1, 32'h301, 0);
        checks++; if (imem_req_o !== 1'b0 || ifid_load_o !== 1'b1 || ifid_bubble_o !== 1'b1) begin errors++; $display("FAIL rds_hold got=%b%b%b exp=011", imem_req_o, ifid_load_o, ifid_bubble_o); end
        drive(0, 0, 0, 1);
        checks++; if (imem_addr_o !== 32'h300 || pc_o !== 32'h300 || ifid_bubble_o !== 1'b0) begin errors++; $display("FAIL rds_hold_target got=%h/%h/%b", imem_addr_o, pc_o, ifid_bubble_o); end
        drive(0, 1, 32'hFFFF_FFFE, 1);
        drive(0, 0, 0, 1);
        checks++; if (imem_addr_o !== 32'hFFFF_FFFC || pcplus4_o !== 32'h0) begin errors++; $display("FAIL wrap_top got=%h/%h exp=fffffffc/00000000", imem_addr_o, pcplus4_o); end
        drive(0, 0, 0, 1);
        checks++; if (imem_addr_o !== 32'h0 || pc_o !== 32'h0) begin errors++; $display("FAIL wrap_zero got=%h/%h exp=0/0", imem_addr_o, pc_o); end
        drive(0, 1, 32'h400, 0);
        drive(0, 1, 32'h500, 0);
        checks++; if (imem_addr_o !== 32'h4 || ifid_bubble_o !== 1'b1) begin errors++; $display("FAIL drop_addr got=%h/%b exp=00000004/1", imem_addr_o, ifid_bubble_o); end
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        checks++; if (imem_addr_o !== 32'h500) begin errors++; $display("FAIL drop_latest got=%h exp=00000500", imem_addr_o); end
        drive(0, 1, 32'h600, 0);
        drive(0, 1, 32'h700, 1);
        drive(0, 0, 0, 1);
        checks++; if (imem_addr_o !== 32'h700) begin errors++; $display("FAIL drop_same_cycle got=%h exp=00000700", imem_addr_o); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);
        checks++; if (fetch_err_o !== 1'b0 || ifid_bubble_o !== 1'b0 || pc_o !== 32'h0) begin errors++; $display("FAIL to_ack_wins got=%b/%b/%h", fetch_err_o, ifid_bubble_o, pc_o); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0);
            checks++; if (fetch_err_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin errors++; $display("FAIL to_wait%0d got=%b/%b/%h", i, fetch_err_o, imem_req_o, imem_addr_o); end
        end
        drive(0, 1, 32'h80, 0);
        checks++; if (fetch_err_o !== 1'b1 || imem_req_o !== 1'b0 || ifid_bubble_o !== 1'b1) begin errors++; $display("FAIL to_err got=%b/%b/%b exp=1/0/1", fetch_err_o, imem_req_o, ifid_bubble_o); end
        drive(0, 0, 0, 0);
        checks++; if (fetch_err_o !== 1'b1 || imem_req_o !== 1'b0) begin errors++; $display("FAIL to_sticky got=%b/%b exp=1/0", fetch_err_o, imem_req_o); end
        do_reset();
        drive(0, 0, 0, 1);
        checks++; if (fetch_err_o !== 1'b0 || imem_addr_o !== 32'h0 || pc_o !== 32'h0) begin errors++; $display("FAIL to_recover got=%b/%h/%h", fetch_err_o, imem_addr_o, pc_o); end
    endtask

    task automatic test_random();
        logic        m_held, m_stale, e_dlv, st, rd, ak, mem_busy;
        logic [31:0] m_addr, m_tgt, m_hpc, e_pc, tgt, tgtm;
        int          lat;
        do_reset();
        m_held = 0; m_stale = 0; m_addr = 32'h0; m_tgt = 0; m_hpc = 0; mem_busy = 0; lat = 0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            #1;
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            tgtm = {tgt[31:2], 2'b00};
            ak = 1'b0;
            if (imem_req_o === 1'b1) begin
                if (!mem_busy) begin lat = $urandom_range(0, 3); mem_busy = 1; end
                ak = (lat == 0);
                if (ak) mem_busy = 0; else lat--;
            end
            stall_i = st; redirect_i = rd; redirect_pc_i = tgt; imem_ack_i = ak;
            imem_rdata_i = ak ? memf(imem_addr_o) : 32'hDEAD_BEEF;
            #1;
            e_dlv = 0; e_pc = 0;
            if (m_held) begin
                if (!rd && !st) begin e_dlv = 1; e_pc = m_hpc; end
            end else if (!rd && !m_stale && ak && !st) begin
                e_dlv = 1; e_pc = m_addr;
            end
            checks++; if (imem_req_o !== !m_held) begin errors++; $display("FAIL rnd_req n=%0d got=%b exp=%b", n, imem_req_o, !m_held); end
            if (!m_held) begin
                checks++; if (imem_addr_o !== m_addr) begin errors++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, imem_addr_o, m_addr); end
            end
            checks++; if (ifid_load_o !== (!st || rd)) begin errors++; $display("FAIL rnd_load n=%0d got=%b exp=%b", n, ifid_load_o, (!st || rd)); end
            checks++; if (ifid_bubble_o !== !e_dlv) begin errors++; $display("FAIL rnd_bubble n=%0d got=%b exp=%b", n, ifid_bubble_o, !e_dlv); end
            if (e_dlv) begin
                checks++; if (pc_o !== e_pc) begin errors++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, pc_o, e_pc); end
                checks++; if (instr_o !== memf(e_pc)) begin errors++; $display("FAIL rnd_instr n=%0d got=%h exp=%h", n, instr_o, memf(e_pc)); end
                checks++; if (pcplus4_o !== e_pc + 32'd4) begin errors++; $display("FAIL rnd_pc4 n=%0d got=%h exp=%h", n, pcplus4_o, e_pc + 32'd4); end
            end
            checks++; if (fetch_err_o !== 1'b0) begin errors++; $display("FAIL rnd_err n=%0d got=%b exp=0", n, fetch_err_o); end
            if (m_held) begin
                if (rd) begin m_held = 0; m_addr = tgtm; end
                else if (!st) m_held = 0;
            end else if (rd) begin
                if (ak) begin m_addr = tgtm; m_stale = 0; end
                else begin m_stale = 1; m_tgt = tgtm; end
            end else if (m_stale) begin
                if (ak) begin m_addr = m_tgt; m_stale = 0; end
            end else if (ak) begin
                if (st) begin m_held = 1; m_hpc = m_addr; end
                m_addr = m_addr + 32'd4;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_latency();
        test_stall_hold();
        test_redirect_pending();
        test_redirect_same_cycle();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
